manchester_decoder: RTL and testbench
=====================================

// Module: manchester_decoder
// PURPOSE
//  Receive-side counterpart of the Manchester transmit stage: oversamples a Manchester line plus its
//  line-enable qualifier and recovers SEQ_LENGTH-bit words, MSB first. Bit coding: first half = bit,
//  second half = ~bit (1 = high->low, 0 = low->high); idle line = 0. Sits on the RX pin ahead of
//  the command/word parser; the line is asynchronous to clk.
// PARAMETERS
//  SEQ_LENGTH  8  bits per frame (>=2)
//  HALF_BIT    4  clk cycles per Manchester half-bit (>=4, even)
// PORTS
//  clk         in   1           oversampling clock; the only clock
//  rst         in   1           synchronous, active-high reset
//  din         in   1           Manchester line (async)
//  din_en      in   1           line-enable/frame qualifier (async); high for whole frame
//  dout        out  SEQ_LENGTH  last decoded word, held until the next good frame
//  dout_valid  out  1           1-cycle pulse: dout updated
//  err         out  1           1-cycle pulse: code violation or early din_en drop
//  busy        out  1           high while a frame is being decoded (FIRST/SECOND)
// BEHAVIOUR
//  - Reset: dout=0, dout_valid=0, err=0, busy=0, state=IDLE, both 2-FF synchronisers=0,
//    counters=0. rst mid-frame aborts with no dout_valid/err pulse.
//  - din and din_en each pass a 2-FF synchroniser; all logic below uses the synchronised
//    versions (s_din, s_en); edge detect on the previous sample.
//  - cnt: 0..HALF_BIT-1 phase counter within a half; bit_cnt: 0..SEQ_LENGTH bits done.
//  - IDLE: on s_en rising edge -> FIRST, cnt=1 (edge cycle is cnt=0), bit_cnt=0.
//  - FIRST: at cnt==HALF_BIT/2 latch s_din as b0. At cnt==HALF_BIT-1 -> SECOND, cnt=0.
//  - SECOND: at cnt==HALF_BIT/2 sample s_din as b1:
//      b1==b0 -> err pulse next cycle, -> WAIT_LOW, no shift.
//      else shreg <= {shreg[SEQ_LENGTH-2:0], b0}, bit_cnt+1; if bit_cnt+1==SEQ_LENGTH:
//      next cycle dout<=new shreg, dout_valid=1 for 1 cycle, -> WAIT_LOW.
//    At cnt==HALF_BIT-1 (not last bit) -> FIRST, cnt=0.
//  - Mid-bit resync: s_din edge in FIRST with cnt>=HALF_BIT-HALF_BIT/4, or in SECOND with
//    cnt<HALF_BIT/4 (and before the b1 sample) -> that cycle is treated as SECOND cnt=0:
//    state<=SECOND, cnt<=1. Edges elsewhere are ignored (bit-boundary edges, glitches).
//  - Tolerates +/-HALF_BIT/4 clocks of half-bit error per bit via resync.
//  - s_en low in FIRST/SECOND before the last b1 sample -> err pulse, -> IDLE, no dout_valid.
//  - WAIT_LOW: ignore s_din; s_en low -> IDLE. A new frame needs a fresh s_en rising edge.
//  - Simultaneous: s_en fall on the same cycle as last b1 sample -> frame is good (valid, no err).
//    err and dout_valid are never high together. err never changes dout.
//  - Latency: dout_valid 1 clk after last-bit second-half sample; ~2 clk after line edges
//    (synchroniser).
//  - busy = (state==FIRST)||(state==SECOND), registered.
// TESTING (SEQ_LENGTH=8, HALF_BIT=4, bench drives 4 clk per half-bit)
//  1. Frame 0xA5 with din_en framing -> single dout_valid pulse, dout=8'hA5, err=0 throughout.
//  2. Back-to-back 0x00 then 0xFF (din_en low 2 clk between) -> two pulses, dout=00 then FF.
//  3. Bit 3 of 0x3C sent high/high (violation) -> one err pulse, no dout_valid, dout unchanged.
//  4. din_en dropped after 4 bits of 0x81 -> one err pulse, busy falls, next frame 0x81 decodes OK.
//  5. Frame 0x5A with alternate halves 3 and 5 clk -> dout=8'h5A via resync, no err.
//  6. rst pulsed during bit 5 of 0xC3 -> all outputs 0, no pulses; next frame 0xC3 decodes correctly.

Source files
------------

// File: rtl/manchester_decoder.sv
// ---------------------------------------------------------------------------
// ManchesterDecoder
//   Receive side of the Manchester line.  It oversamples the asynchronous
//   line and its frame qualifier and recovers SEQ_LENGTH-bit words, MSB
//   first.  A '1' is sent high->low and a '0' low->high.  The idle line is 0.
//
// Ports
//   clk        oversampling clock, the only clock
//   rst        synchronous active-high reset
//   din        Manchester line (asynchronous)
//   din_en     frame qualifier (asynchronous), high for the whole frame
//   dout       last good word, held until the next good frame
//   dout_valid one-cycle pulse when dout is updated
//   err        one-cycle pulse on a code violation or an early din_en drop
//   busy       high while a frame is being decoded
// ---------------------------------------------------------------------------
module manchester_decoder #(
    parameter int SEQ_LENGTH = 8,
    parameter int HALF_BIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  din_en,
    output logic [SEQ_LENGTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int CW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int BW = $clog2(SEQ_LENGTH + 1);

    localparam logic [CW-1:0] L_MID     = CW'(HALF_BIT / 2);
    localparam logic [CW-1:0] L_LAST    = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] L_LATE    = CW'(HALF_BIT - HALF_BIT / 4);
    localparam logic [CW-1:0] L_EARLY   = CW'(HALF_BIT / 4);
    localparam logic [BW-1:0] L_LASTBIT = BW'(SEQ_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        WAIT_LOW
    } state_t;

    logic                  r_dinMeta, r_dinSync, r_dinPrev;
    logic                  r_enMeta, r_enSync, r_enPrev;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bitCnt;
    logic                  r_b0;
    logic [SEQ_LENGTH-1:0] r_shreg;
    logic [SEQ_LENGTH-1:0] r_dout;
    logic                  r_doutValid;
    logic                  r_err;
    logic                  r_busy;

    state_t                w_stateNext;
    logic [CW-1:0]         w_cntNext;
    logic [BW-1:0]         w_bitCntNext;
    logic                  w_b0Next;
    logic [SEQ_LENGTH-1:0] w_shregNext;
    logic [SEQ_LENGTH-1:0] w_doutNext;
    logic                  w_validNext;
    logic                  w_errNext;
    logic                  w_enRise;
    logic                  w_dinEdge;
    logic                  w_lastSample;
    logic [SEQ_LENGTH-1:0] w_shifted;

    // Edge detection works on the synchronised samples against the previous
    // synchronised sample, never on the raw asynchronous pins.
    assign w_enRise     = r_enSync & ~r_enPrev;
    assign w_dinEdge    = r_dinSync ^ r_dinPrev;
    assign w_lastSample = (r_cnt == L_MID) && (r_bitCnt == L_LASTBIT);
    assign w_shifted    = {r_shreg[SEQ_LENGTH-2:0], r_b0};

    // Two-flop synchronisers plus all state and output registers.  Outputs
    // are registered so the pulses come out one clock after the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dinMeta   <= 1'b0;
            r_dinSync   <= 1'b0;
            r_dinPrev   <= 1'b0;
            r_enMeta    <= 1'b0;
            r_enSync    <= 1'b0;
            r_enPrev    <= 1'b0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bitCnt    <= '0;
            r_b0        <= 1'b0;
            r_shreg     <= '0;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_dinMeta   <= din;
            r_dinSync   <= r_dinMeta;
            r_dinPrev   <= r_dinSync;
            r_enMeta    <= din_en;
            r_enSync    <= r_enMeta;
            r_enPrev    <= r_enSync;
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_bitCnt    <= w_bitCntNext;
            r_b0        <= w_b0Next;
            r_shreg     <= w_shregNext;
            r_dout      <= w_doutNext;
            r_doutValid <= w_validNext;
            r_err       <= w_errNext;
            r_busy      <= (w_stateNext == FIRST) || (w_stateNext == SECOND);
        end
    end

    // Next-state logic.  A mid-bit edge seen late in FIRST or early in
    // SECOND re-centres the phase counter as if that cycle were SECOND cnt=0,
    // which absorbs up to a quarter half-bit of timing error per bit.  The
    // enable check in SECOND lets the final b1 sample win over a coincident
    // din_en drop so that frame still counts as good.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_bitCntNext = r_bitCnt;
        w_b0Next     = r_b0;
        w_shregNext  = r_shreg;
        w_doutNext   = r_dout;
        w_validNext  = 1'b0;
        w_errNext    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_enRise) begin
                    w_stateNext  = FIRST;
                    w_cntNext    = CW'(1);
                    w_bitCntNext = '0;
                end
            end
            FIRST: begin
                if (!r_enSync) begin
                    w_errNext   = 1'b1;
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (w_dinEdge && (r_cnt >= L_LATE)) begin
                    w_stateNext = SECOND;
                    w_cntNext   = CW'(1);
                end else begin
                    if (r_cnt == L_MID) begin
                        w_b0Next = r_dinSync;
                    end
                    if (r_cnt == L_LAST) begin
                        w_stateNext = SECOND;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            end
            SECOND: begin
                if (!r_enSync && !w_lastSample) begin
                    w_errNext   = 1'b1;
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (r_cnt == L_MID) begin
                    if (r_dinSync == r_b0) begin
                        w_errNext   = 1'b1;
                        w_stateNext = WAIT_LOW;
                        w_cntNext   = '0;
                    end else begin
                        w_shregNext  = w_shifted;
                        w_bitCntNext = r_bitCnt + 1'b1;
                        if (r_bitCnt == L_LASTBIT) begin
                            w_doutNext  = w_shifted;
                            w_validNext = 1'b1;
                            w_stateNext = WAIT_LOW;
                            w_cntNext   = '0;
                        end else begin
                            w_cntNext = r_cnt + 1'b1;
                        end
                    end
                end else if (w_dinEdge && (r_cnt < L_EARLY)) begin
                    w_cntNext = CW'(1);
                end else if (r_cnt == L_LAST) begin
                    w_stateNext = FIRST;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!r_enSync) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign err        = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_manchester_decoder.sv
// ---------------------------------------------------------------------------
// TbManchesterDecoder
//   Drives Manchester frames into manchester_decoder from a vector table and
//   compares the pulse counts, held word and busy flag against hand-computed
//   values.  A mid-frame reset is exercised as a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_manchester_decoder;

    localparam int SEQ_LENGTH = 8;
    localparam int HALF_BIT   = 4;
    localparam int NUM_VECS   = 7;

    logic                  clk;
    logic                  rst;
    logic                  din;
    logic                  din_en;
    logic [SEQ_LENGTH-1:0] dout;
    logic                  dout_valid;
    logic                  err;
    logic                  busy;

    int checks;
    int errors;
    int validCnt;
    int errCnt;
    int bothCnt;
    int busySeen;

    typedef struct {
        logic [7:0] word;
        int         violBit;
        int         bitsSent;
        int         halfA;
        int         halfB;
        int         gap;
        int         expValid;
        int         expErr;
        logic [7:0] expDout;
    } vec_t;

    vec_t vecs [NUM_VECS];

    manchester_decoder #(
        .SEQ_LENGTH(SEQ_LENGTH),
        .HALF_BIT  (HALF_BIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .dout      (dout),
        .dout_valid(dout_valid),
        .err       (err),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor: samples 1 ns after each rising edge, away from the
    // register updates, and tallies the pulses the main sequence inspects.
    always @(posedge clk) begin
        #1;
        if (dout_valid) validCnt = validCnt + 1;
        if (err) errCnt = errCnt + 1;
        if (dout_valid && err) bothCnt = bothCnt + 1;
        if (busy) busySeen = 1;
    end

    // One comparison: counts it and reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Clears the monitor tallies; called on a falling edge so it never
    // races the monitor.
    task automatic clearMonitor();
        validCnt = 0;
        errCnt   = 0;
        bothCnt  = 0;
        busySeen = 0;
    endtask

    // Sends the top bitsSent bits of a word MSB first with the given half
    // lengths, optionally repeating the first half into the second half of
    // one bit to force a code violation, then drops the frame for gap clocks.
    task automatic applyStimulus(input logic [7:0] word, input int violBit, input int bitsSent,
                                 input int halfA, input int halfB, input int gap);
        logic b;
        din_en = 1'b1;
        for (int i = SEQ_LENGTH - 1; i >= SEQ_LENGTH - bitsSent; i--) begin
            b   = word[i];
            din = b;
            repeat (halfA) @(negedge clk);
            din = (i == violBit) ? b : ~b;
            repeat (halfB) @(negedge clk);
        end
        din_en = 1'b0;
        din    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Main sequence: reset checks, table of frames, then the mid-frame reset.
    initial begin
        checks   = 0;
        errors   = 0;
        validCnt = 0;
        errCnt   = 0;
        bothCnt  = 0;
        busySeen = 0;
        rst      = 1'b1;
        din      = 1'b0;
        din_en   = 1'b0;

        vecs[0] = '{8'hA5, -1, 8, 4, 4, 6, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, -1, 8, 4, 4, 2, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, -1, 8, 4, 4, 6, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C,  3, 8, 4, 4, 6, 0, 1, 8'hFF};
        vecs[4] = '{8'h81, -1, 4, 4, 4, 8, 0, 1, 8'hFF};
        vecs[5] = '{8'h81, -1, 8, 4, 4, 6, 1, 0, 8'h81};
        vecs[6] = '{8'h5A, -1, 8, 3, 5, 6, 1, 0, 8'h5A};

        repeat (3) @(negedge clk);
        checkOutput("reset dout", 32'(dout), 32'h0);
        checkOutput("reset dout_valid", 32'(dout_valid), 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < NUM_VECS; v++) begin
            clearMonitor();
            applyStimulus(vecs[v].word, vecs[v].violBit, vecs[v].bitsSent,
                          vecs[v].halfA, vecs[v].halfB, vecs[v].gap);
            checkOutput($sformatf("vec%0d valid pulses", v), 32'(validCnt), 32'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d err pulses", v), 32'(errCnt), 32'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d valid+err overlap", v), 32'(bothCnt), 32'h0);
            checkOutput($sformatf("vec%0d dout", v), 32'(dout), 32'(vecs[v].expDout));
            checkOutput($sformatf("vec%0d busy seen", v), 32'(busySeen), 32'h1);
            checkOutput($sformatf("vec%0d busy idle", v), 32'(busy), 32'h0);
        end

        // Mid-frame reset: five bits of 0xC3 plus half of the sixth, then
        // reset with the line dropped; nothing may pulse and dout clears.
        clearMonitor();
        din_en = 1'b1;
        for (int i = 7; i >= 3; i--) begin
            din = vecs[0].word[0] ^ vecs[0].word[0] ^ (8'hC3 >> i) & 1'b1;
            repeat (HALF_BIT) @(negedge clk);
            din = ~din;
            repeat (HALF_BIT) @(negedge clk);
        end
        din = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst busy before", 32'(busy), 32'h1);
        rst    = 1'b1;
        din_en = 1'b0;
        din    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrst dout", 32'(dout), 32'h0);
        checkOutput("midrst dout_valid", 32'(dout_valid), 32'h0);
        checkOutput("midrst err", 32'(err), 32'h0);
        checkOutput("midrst busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midrst valid pulses", 32'(validCnt), 32'h0);
        checkOutput("midrst err pulses", 32'(errCnt), 32'h0);

        // Clean 0xC3 frame after the reset.
        clearMonitor();
        applyStimulus(8'hC3, -1, 8, 4, 4, 6);
        checkOutput("post-rst valid pulses", 32'(validCnt), 32'h1);
        checkOutput("post-rst err pulses", 32'(errCnt), 32'h0);
        checkOutput("post-rst dout", 32'(dout), 32'hC3);
        checkOutput("post-rst busy idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
